// File: rtl/temp_level_scheduler.sv
// temp_level_scheduler
// Classifies one temperature sample against N_THRESH thresholds read one at a
// time through a shared select/data port (lim_sel -> lim_dado), and checks one
// humidity sample against lim_um. A single comparator scans the thresholds
// in order. The scan stalls whenever the configuration bank is being
// rewritten.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   iniciar             start request, only honoured when idle
//   temperatura/umidade samples, captured at the start of a scan
//   config_ocupado      configuration reception in progress (blocks/aborts)
//   config_valida       bank holds a complete, parity-clean configuration
//   lim_sel / lim_dado  threshold index out, selected threshold in
//   lim_um              humidity limit
//   nivel               level 0..N_THRESH (first threshold > sample)
//   alarme_umidade      umidade >= lim_um, latched at capture
//   ocupado             high whenever not idle
//   pronto              one-cycle pulse at end of classification or error
//   erro_sem_config     start refused for lack of a valid configuration
//   db_estado           current state code
module temp_level_scheduler #(
  parameter int WIDTH    = 8,
  parameter int N_THRESH = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic [WIDTH-1:0] temperatura,
  input  logic [WIDTH-1:0] umidade,
  input  logic             config_ocupado,
  input  logic             config_valida,
  output logic [2:0]       lim_sel,
  input  logic [WIDTH-1:0] lim_dado,
  input  logic [WIDTH-1:0] lim_um,
  output logic [2:0]       nivel,
  output logic             alarme_umidade,
  output logic             ocupado,
  output logic             pronto,
  output logic             erro_sem_config,
  output logic [3:0]       db_estado
);

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    ESPERA_CONFIG = 4'd1,
    CAPTURA       = 4'd2,
    SELECIONA     = 4'd3,
    COMPARA       = 4'd4,
    FIM           = 4'd5,
    ERRO          = 4'd6
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(N_THRESH - 1);
  localparam logic [2:0] TOP_LVL  = 3'(N_THRESH);

  state_t           state, state_nx;
  logic [2:0]       idx;
  logic [WIDTH-1:0] temp_reg;
  logic             hit;

  // Strictly-less: a sample equal to a threshold falls through to the next.
  assign hit = temp_reg < lim_dado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= OCIOSO;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      OCIOSO: begin
        if (iniciar) begin
          if (config_ocupado)      state_nx = ESPERA_CONFIG;
          else if (!config_valida) state_nx = ERRO;
          else                     state_nx = CAPTURA;
        end
      end
      ESPERA_CONFIG: begin
        if (!config_ocupado) state_nx = config_valida ? CAPTURA : ERRO;
      end
      CAPTURA:   state_nx = config_ocupado ? ESPERA_CONFIG : SELECIONA;
      SELECIONA: state_nx = config_ocupado ? ESPERA_CONFIG : COMPARA;
      COMPARA: begin
        if (config_ocupado)              state_nx = ESPERA_CONFIG;
        else if (hit || idx == LAST_IDX) state_nx = FIM;
        else                             state_nx = SELECIONA;
      end
      FIM:     state_nx = OCIOSO;
      ERRO:    state_nx = OCIOSO;
      default: state_nx = OCIOSO;
    endcase
  end

  // Datapath. An abort (config_ocupado mid-scan) writes no result; the
  // rescan always restarts from CAPTURA with a fresh sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx             <= '0;
      temp_reg        <= '0;
      nivel           <= '0;
      alarme_umidade  <= 1'b0;
      erro_sem_config <= 1'b0;
    end else begin
      // Set on entry so the flag is already visible during the pronto cycle.
      if (state_nx == ERRO) erro_sem_config <= 1'b1;
      if (state_nx == ESPERA_CONFIG) idx <= '0;
      case (state)
        CAPTURA: if (!config_ocupado) begin
          temp_reg        <= temperatura;
          alarme_umidade  <= umidade >= lim_um;
          idx             <= '0;
          erro_sem_config <= 1'b0;
        end
        COMPARA: if (!config_ocupado) begin
          if (hit)                  nivel <= idx;
          else if (idx == LAST_IDX) nivel <= TOP_LVL;
          else                      idx   <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign lim_sel   = idx;
  assign ocupado   = state != OCIOSO;
  assign pronto    = (state == FIM) || (state == ERRO);
  assign db_estado = state;

endmodule

// File: tb/tb_temp_level_scheduler.sv
// Self-checking bench for temp_level_scheduler: directed scenarios plus
// randomized scans compared against a first-match level model.
module tb_temp_level_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [7:0] temperatura, umidade;
  logic       config_ocupado, config_valida;
  logic [2:0] lim_sel;
  logic [7:0] lim_dado, lim_um;
  logic [2:0] nivel;
  logic       alarme_umidade, ocupado, pronto, erro_sem_config;
  logic [3:0] db_estado;

  logic [7:0] thr [8];
  assign lim_dado = thr[lim_sel];

  int n_cmp = 0;
  int n_bad = 0;
  int m_lvl = 0;   // model of last written level
  int m_alm = 0;   // model of last written humidity alarm

  always #5 clock = ~clock;

  temp_level_scheduler dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .temperatura(temperatura), .umidade(umidade),
    .config_ocupado(config_ocupado), .config_valida(config_valida),
    .lim_sel(lim_sel), .lim_dado(lim_dado), .lim_um(lim_um),
    .nivel(nivel), .alarme_umidade(alarme_umidade), .ocupado(ocupado),
    .pronto(pronto), .erro_sem_config(erro_sem_config), .db_estado(db_estado)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Level = index of the first threshold strictly above the sample.
  function automatic int model_level(input int t);
    for (int i = 0; i < 7; i++) if (t < int'(thr[i])) return i;
    return 7;
  endfunction

  function automatic int model_lat(input int k);
    return (k < 7) ? 3 + 2 * k : 15;
  endfunction

  task automatic set_thr(input int a0, a1, a2, a3, a4, a5, a6);
    thr[0] = 8'(a0); thr[1] = 8'(a1); thr[2] = 8'(a2); thr[3] = 8'(a3);
    thr[4] = 8'(a4); thr[5] = 8'(a5); thr[6] = 8'(a6); thr[7] = 8'd0;
  endtask

  // Called right after the edge that moved the FSM into CAPTURA.
  task automatic wait_result(input string tag, input int t, input int u);
    int n = 0;
    int k;
    k = model_level(t);
    while (!pronto && n < 40) begin step(); n++; end
    m_lvl = k;
    m_alm = (u >= int'(lim_um)) ? 1 : 0;
    chk({tag, ".lat"}, n, model_lat(k));
    chk({tag, ".nivel"}, int'(nivel), m_lvl);
    chk({tag, ".alarm"}, int'(alarme_umidade), m_alm);
    chk({tag, ".erro"}, int'(erro_sem_config), 0);
    step();
    chk({tag, ".pulse"}, int'(pronto), 0);
    chk({tag, ".idle"}, int'(db_estado), 0);
  endtask

  task automatic run_scan(input string tag, input int t, input int u);
    temperatura = 8'(t); umidade = 8'(u);
    iniciar = 1'b1; step(); iniciar = 1'b0;
    wait_result(tag, t, u);
  endtask

  initial begin
    int guard, cnt, prev, t, u;
    reset = 1'b1; iniciar = 0; temperatura = 0; umidade = 0;
    config_ocupado = 0; config_valida = 1; lim_um = 8'd80;
    set_thr(10, 20, 30, 40, 50, 60, 70);
    step(); step();
    chk("rst.state", int'(db_estado), 0);
    chk("rst.nivel", int'(nivel), 0);
    chk("rst.pronto", int'(pronto), 0);
    chk("rst.ocupado", int'(ocupado), 0);
    reset = 1'b0;
    step();

    run_scan("mid", 25, 50);
    run_scan("eq_last", 70, 10);
    run_scan("low", 5, 80);

    // Start without a valid configuration.
    config_valida = 0;
    iniciar = 1; step(); iniciar = 0;
    chk("err.state", int'(db_estado), 6);
    chk("err.pronto", int'(pronto), 1);
    chk("err.flag", int'(erro_sem_config), 1);
    chk("err.nivel", int'(nivel), m_lvl);
    step();
    chk("err.pulse", int'(pronto), 0);
    chk("err.hold", int'(erro_sem_config), 1);
    config_valida = 1;
    run_scan("after_err", 35, 10);

    // Start while configuration is being received.
    config_ocupado = 1; temperatura = 45; umidade = 90;
    iniciar = 1; step(); iniciar = 0;
    chk("wait.state", int'(db_estado), 1);
    chk("wait.ocupado", int'(ocupado), 1);
    step(); step();
    chk("wait.hold", int'(db_estado), 1);
    config_ocupado = 0; step();
    wait_result("wait", 45, 90);

    // Abort in COMPARA at idx 3, rescan with a new sample.
    temperatura = 65; umidade = 0;
    iniciar = 1; step(); iniciar = 0;
    guard = 0;
    while (!(db_estado == 4 && lim_sel == 3) && guard < 40) begin step(); guard++; end
    chk("abort.reach", guard < 40 ? 1 : 0, 1);
    config_ocupado = 1; step();
    chk("abort.state", int'(db_estado), 1);
    chk("abort.pronto", int'(pronto), 0);
    chk("abort.nivel", int'(nivel), m_lvl);
    temperatura = 15; umidade = 85;
    step();
    chk("abort.pronto2", int'(pronto), 0);
    config_ocupado = 0; step();
    wait_result("abort", 15, 85);

    // Reset in the middle of a scan.
    run_scan("pre_rst", 55, 95);
    temperatura = 65;
    iniciar = 1; step(); iniciar = 0;
    guard = 0;
    while (lim_sel != 4 && guard < 40) begin step(); guard++; end
    chk("rst2.reach", guard < 40 ? 1 : 0, 1);
    #2 reset = 1; #1;
    chk("rst2.state", int'(db_estado), 0);
    chk("rst2.nivel", int'(nivel), 0);
    chk("rst2.pronto", int'(pronto), 0);
    chk("rst2.alarm", int'(alarme_umidade), 0);
    chk("rst2.sel", int'(lim_sel), 0);
    m_lvl = 0; m_alm = 0;
    step(); reset = 0; step();

    // iniciar held high: pronto at 7,16,25,34,43 edges after the first start.
    temperatura = 25; umidade = 10;
    iniciar = 1; step();
    cnt = 0; prev = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (pronto) cnt++;
      if (pronto && prev) chk("held.width", 2, 1);
      prev = int'(pronto);
    end
    chk("held.count", cnt, 5);
    iniciar = 0;
    for (int i = 0; i < 20; i++) step();
    chk("held.idle", int'(db_estado), 0);

    // Randomized scans with unordered thresholds and equality corner cases.
    for (int r = 0; r < 30; r++) begin
      set_thr($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255));
      lim_um = 8'($urandom_range(0, 255));
      t = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) t = int'(thr[$urandom_range(0, 6)]);
      u = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) u = int'(lim_um);
      run_scan("rnd", t, u);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/temp_level_scheduler.md
Name: temp_level_scheduler

Overview:
- Sequencing controller that classifies one temperature sample against the 7 configured temperature thresholds and checks one humidity sample against the configured humidity limit.
- Shares the threshold register bank through a single select/data port and uses one comparator, scanning the thresholds sequentially.
- Sits between the sensor-read path and the configuration bank.
- Blocks while a configuration reception is in progress.

Parameters:
WIDTH, 8, width of temperature, humidity and threshold words
N_THRESH, 7, number of temperature thresholds scanned (indices 0..N_THRESH-1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
iniciar  input  1  start request; sampled only in OCIOSO
temperatura  input  WIDTH  temperature sample, latched in CAPTURA
umidade  input  WIDTH  humidity sample, latched in CAPTURA
config_ocupado  input  1  high while configuration reception is running
config_valida  input  1  high when the bank holds a complete, parity-clean configuration
lim_sel  output  3  threshold index driven to the bank mux
lim_dado  input  WIDTH  threshold selected by lim_sel (combinational from bank)
lim_um  input  WIDTH  humidity limit register
nivel  output  3  result level 0..7
alarme_umidade  output  1  latched: umidade >= lim_um
ocupado  output  1  high in every state except OCIOSO
pronto  output  1  one-cycle pulse at end of classification or error
erro_sem_config  output  1  latched: start refused for lack of valid configuration
db_estado  output  4  current state code

Behaviour:
- Reset (async): state OCIOSO; idx=0; lim_sel=0; nivel=0; alarme_umidade=0; pronto=0; erro_sem_config=0; temp/umid registers=0.
- States and codes: OCIOSO=0, ESPERA_CONFIG=1, CAPTURA=2, SELECIONA=3, COMPARA=4, FIM=5, ERRO=6. Codes 7..15 go to OCIOSO.
- OCIOSO:
  - iniciar=0: stay.
  - iniciar=1 and config_ocupado=1: go to ESPERA_CONFIG (config_ocupado has priority).
  - iniciar=1 and config_valida=0: go to ERRO.
  - Otherwise: go to CAPTURA.
- ESPERA_CONFIG: stay while config_ocupado=1. When it falls, go to CAPTURA if config_valida=1, else ERRO.
- CAPTURA (1 cycle):
  - Latch temperatura and umidade.
  - Set alarme_umidade = (umidade >= lim_um), unsigned.
  - Clear idx and erro_sem_config.
  - Go to SELECIONA.
- SELECIONA (1 cycle): lim_sel=idx. Go to COMPARA.
- COMPARA: lim_sel still equals idx; compare unsigned against lim_dado.
  - temp_reg < lim_dado: nivel=idx, go to FIM.
  - Else if idx == N_THRESH-1: nivel=N_THRESH (7), go to FIM.
  - Else: idx increments, go to SELECIONA.
- First-match rule: nivel = index of the first threshold strictly greater than the sample. Ordering of thresholds is not checked. Equality with a threshold does not match.
- FIM: pronto=1 for exactly this cycle. Go to OCIOSO.
- ERRO: set erro_sem_config=1 and pulse pronto for this cycle. Go to OCIOSO. erro_sem_config holds until the next CAPTURA.
- nivel and alarme_umidade hold their values until overwritten by the next completed classification or CAPTURA. ERRO leaves them unchanged.
- Latency: with iniciar sampled at edge e0, pronto is high after edge e0+3+2k for nivel=k (k<7); nivel=7 → e0+15.
- Abort: config_ocupado=1 in CAPTURA, SELECIONA or COMPARA:
  - Go to ESPERA_CONFIG.
  - No result is written; partial idx is discarded.
  - Rescan from CAPTURA with a fresh sample.
- iniciar asserted outside OCIOSO is ignored (not queued).
- Reset mid-scan returns all outputs to reset values immediately.

Test Plan:
- Thresholds 10,20,30,40,50,60,70; lim_um=80; valid config; temperatura=25, umidade=50 → nivel=2, alarme_umidade=0, pronto 1 cycle at e0+7.
- Same thresholds, temperatura=70 (equal to last) → nivel=7, pronto at e0+15. temperatura=5, umidade=80 → nivel=0, alarme_umidade=1, pronto at e0+3.
- config_valida=0, iniciar pulse → ERRO, erro_sem_config=1, pronto 1 cycle, nivel unchanged. A later valid run with temperatura=35 → erro_sem_config=0, nivel=3.
- config_ocupado=1 when iniciar arrives → ESPERA_CONFIG (db_estado=1), ocupado=1. config_ocupado falls with valid=1 → scan completes normally.
- config_ocupado raised while in COMPARA at idx=3 → ESPERA_CONFIG, no pronto. On release, rescan from idx 0 with the new sample.
- Reset asserted at idx=4 → db_estado=0, nivel=0, pronto=0 asynchronously. iniciar held high through the scan produces exactly one pronto per OCIOSO visit.
